// File: rtl/pipes_pkg.sv
// Shared pipeline types: instruction-bus structs, fetch-queue entry and state encoding.
package pipes;

   typedef logic [63:0] word_t;
   typedef logic [31:0] u32;

   typedef struct packed {
      logic  valid;
      word_t addr;
   } ibus_req_t;

   typedef struct packed {
      logic data_ok;
      u32   data;
   } ibus_resp_t;

   typedef struct packed {
      word_t pc;
      u32    instr;
   } fetchq_entry_t;

   typedef enum logic [1:0] {
      FQ_IDLE,
      FQ_REQ,
      FQ_DROP
   } fetchq_state_t;

   localparam word_t FETCH_STEP = 64'd4;

   // Instructions are word aligned; the low two PC bits are never meaningful.
   function automatic word_t align_pc(word_t pc);
      return {pc[63:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetchq_fifo.sv
// Circular buffer of fetched {pc, instr} entries with push, pop, clear and occupancy.
module fetchq_fifo
   import pipes::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  fetchq_entry_t          push_data,
   input  logic                   pop,
   input  logic                   clear,
   output logic [$clog2(DEPTH):0] count,
   output fetchq_entry_t          head
);

   localparam int unsigned AW = $clog2(DEPTH);

   fetchq_entry_t mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   cnt;

   // Pointer, occupancy and storage update; clear wins over push/pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (clear) begin
         // Leave rd_ptr alone so the stale head stays put while empty.
         wr_ptr <= rd_ptr;
         cnt    <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: ;
         endcase
      end
   end

   assign count = cnt;
   assign head  = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: one outstanding ibus request, DEPTH-entry instruction
// queue, and redirect handling that discards a response already in flight.
module fetch_queue
   import pipes::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter word_t       RESET_PC = 64'h8000_0000
) (
   input  logic                   clk,
   input  logic                   reset,
   output ibus_req_t              ireq,
   input  ibus_resp_t             iresp,
   input  logic                   redirect_valid,
   input  logic [63:0]            redirect_pc,
   output logic                   out_valid,
   output logic [63:0]            out_pc,
   output logic [31:0]            out_instr,
   input  logic                   out_ready,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   fetchq_state_t state_q, state_d;
   word_t         fpc_q, fpc_d;
   word_t         tgt_q, tgt_d;

   word_t         redir_pc;
   logic          deq;
   logic          push;
   logic [CW-1:0] count_after_deq;
   logic          space_after_deq;
   logic          space_after_enq;
   fetchq_entry_t push_data;
   fetchq_entry_t head;

   // State, fetch PC and pending redirect target registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FQ_IDLE;
         fpc_q   <= RESET_PC;
         tgt_q   <= '0;
      end else begin
         state_q <= state_d;
         fpc_q   <= fpc_d;
         tgt_q   <= tgt_d;
      end
   end

   // Next-state, PC update and enqueue decision.
   always_comb begin
      state_d  = state_q;
      fpc_d    = fpc_q;
      tgt_d    = tgt_q;
      push     = 1'b0;
      redir_pc = align_pc(redirect_pc);

      // A redirect flushes the queue, so a same-cycle pop is irrelevant.
      deq             = out_valid & out_ready & ~redirect_valid;
      count_after_deq = count - {{(CW-1){1'b0}}, deq};
      space_after_deq = count_after_deq < FULL;
      space_after_enq = count_after_deq < (FULL - 1'b1);

      case (state_q)
         FQ_IDLE: begin
            if (redirect_valid) begin
               fpc_d = redir_pc;
            end else if (space_after_deq) begin
               state_d = FQ_REQ;
            end
         end
         FQ_REQ: begin
            if (iresp.data_ok) begin
               if (redirect_valid) begin
                  fpc_d   = redir_pc;
                  state_d = FQ_REQ;
               end else begin
                  push    = 1'b1;
                  fpc_d   = fpc_q + FETCH_STEP;
                  state_d = space_after_enq ? FQ_REQ : FQ_IDLE;
               end
            end else if (redirect_valid) begin
               // Bus address must stay stable, so park the new PC until the response lands.
               tgt_d   = redir_pc;
               state_d = FQ_DROP;
            end
         end
         FQ_DROP: begin
            if (iresp.data_ok) begin
               fpc_d   = redirect_valid ? redir_pc : tgt_q;
               state_d = FQ_REQ;
            end else if (redirect_valid) begin
               tgt_d = redir_pc;
            end
         end
         default: begin
            state_d = FQ_IDLE;
         end
      endcase
   end

   assign push_data = '{pc: fpc_q, instr: iresp.data};

   fetchq_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .push_data(push_data),
      .pop      (deq),
      .clear    (redirect_valid),
      .count    (count),
      .head     (head)
   );

   assign ireq.valid = (state_q != FQ_IDLE);
   assign ireq.addr  = fpc_q;
   assign out_valid  = (count != '0);
   assign out_pc     = head.pc;
   assign out_instr  = head.instr;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a transaction-level model (queue of entries plus an
// outstanding/discard flag) is compared every cycle, with literal spot checks on top.
module tb_fetch_queue;
   import pipes::*;

   localparam int unsigned DEPTH    = 4;
   localparam logic [63:0] RESET_PC = 64'h8000_0000;

   logic                   clk = 1'b0;
   logic                   reset;
   ibus_req_t              ireq;
   ibus_resp_t             iresp;
   logic                   redirect_valid;
   logic [63:0]            redirect_pc;
   logic                   out_valid;
   logic [63:0]            out_pc;
   logic [31:0]            out_instr;
   logic                   out_ready;
   logic [$clog2(DEPTH):0] count;

   always #5 clk = ~clk;

   fetch_queue #(
      .DEPTH   (DEPTH),
      .RESET_PC(RESET_PC)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .ireq          (ireq),
      .iresp         (iresp),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .out_valid     (out_valid),
      .out_pc        (out_pc),
      .out_instr     (out_instr),
      .out_ready     (out_ready),
      .count         (count)
   );

   typedef struct {
      logic [63:0] pc;
      logic [31:0] instr;
   } ent_t;

   ent_t        mq[$];
   logic [63:0] m_fpc;
   logic [63:0] m_tgt;
   bit          m_out;
   bit          m_disc;
   int          wait_cnt;
   int          lat = 1;
   int          n_pass = 0;
   int          n_total = 0;
   bit          chk_en = 1'b0;

   function automatic logic [31:0] bus_data(logic [63:0] a);
      return a[31:0] ^ 32'hC0DE_0000;
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", name, act, exp);
   endtask

   task automatic model_reset();
      mq.delete();
      m_fpc    = RESET_PC;
      m_tgt    = '0;
      m_out    = 1'b0;
      m_disc   = 1'b0;
      wait_cnt = 0;
   endtask

   // One clock edge of the fetch front end, expressed as queue and transaction bookkeeping.
   task automatic model_step(bit rv, logic [63:0] rpc, bit dok, bit ordy, logic [31:0] d);
      logic [63:0] ra;
      bit          was_out;
      ra      = {rpc[63:2], 2'b00};
      was_out = m_out;
      if (rv) begin
         mq.delete();
         if (!m_out) begin
            m_fpc = ra;
         end else if (dok) begin
            m_fpc  = ra;
            m_disc = 1'b0;
         end else begin
            m_disc = 1'b1;
            m_tgt  = ra;
         end
      end else begin
         if (mq.size() > 0 && ordy) void'(mq.pop_front());
         if (m_out && dok) begin
            if (m_disc) begin
               m_fpc  = m_tgt;
               m_disc = 1'b0;
            end else begin
               mq.push_back('{m_fpc, d});
               m_fpc = m_fpc + 64'd4;
               m_out = (mq.size() < DEPTH);
            end
         end else if (!m_out) begin
            m_out = (mq.size() < DEPTH);
         end
      end
      wait_cnt = (was_out && !dok) ? wait_cnt + 1 : 0;
   endtask

   // Drive one cycle of stimulus; the bus answers after `lat` cycles of a transaction.
   task automatic cycle(bit rv, logic [63:0] rpc, bit ordy);
      bit          dok;
      logic [31:0] d;
      dok                = m_out && (wait_cnt + 1 >= lat);
      d                  = bus_data(m_fpc);
      redirect_valid     = rv;
      redirect_pc        = rpc;
      out_ready          = ordy;
      iresp.data_ok      = dok;
      iresp.data         = dok ? d : 32'hDEAD_BEEF;
      @(posedge clk);
      model_step(rv, rpc, dok, ordy, d);
      #1;
   endtask

   task automatic do_reset();
      chk_en         = 1'b0;
      reset          = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      out_ready      = 1'b0;
      iresp.data_ok  = 1'b0;
      iresp.data     = '0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      check("rst_count", 64'(count), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_ireq_valid", 64'(ireq.valid), 64'd0);
      check("rst_ireq_addr", ireq.addr, RESET_PC);
      check("rst_out_pc", out_pc, 64'd0);
      check("rst_out_instr", 64'(out_instr), 64'd0);
      reset  = 1'b0;
      chk_en = 1'b1;
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en && !reset) begin
         check("out_valid", 64'(out_valid), 64'(mq.size() > 0));
         check("count", 64'(count), 64'(mq.size()));
         check("ireq_valid", 64'(ireq.valid), 64'(m_out));
         if (m_out) check("ireq_addr", ireq.addr, m_fpc);
         if (mq.size() > 0) begin
            check("out_pc", out_pc, mq[0].pc);
            check("out_instr", 64'(out_instr), 64'(mq[0].instr));
         end
      end
   end

   initial begin
      // Zero-latency bus, consumer always ready: one instruction per cycle.
      do_reset();
      lat = 1;
      cycle(0, '0, 1);
      check("s1_first_req_valid", 64'(ireq.valid), 64'd1);
      check("s1_first_req_addr", ireq.addr, 64'h8000_0000);
      for (int i = 0; i < 6; i++) begin
         cycle(0, '0, 1);
         check("s1_stream_pc", out_pc, 64'h8000_0000 + 64'(4 * i));
         check("s1_stream_instr", 64'(out_instr), 64'(bus_data(64'h8000_0000 + 64'(4 * i))));
      end

      // Consumer stalled: queue fills, fetch stops, one pop re-opens one request.
      do_reset();
      repeat (6) cycle(0, '0, 0);
      check("s2_full_count", 64'(count), 64'd4);
      check("s2_full_ireq_valid", 64'(ireq.valid), 64'd0);
      cycle(0, '0, 1);
      check("s2_reissue_valid", 64'(ireq.valid), 64'd1);
      check("s2_reissue_addr", ireq.addr, 64'h8000_0010);
      repeat (3) cycle(0, '0, 0);

      // 3-cycle bus, redirect while the 8000_0004 request is in flight.
      do_reset();
      lat = 3;
      repeat (5) cycle(0, '0, 1);
      check("s3_issue_addr", ireq.addr, 64'h8000_0004);
      cycle(1, 64'h8000_1000, 1);
      check("s3_drop_addr_held", ireq.addr, 64'h8000_0004);
      check("s3_drop_valid", 64'(ireq.valid), 64'd1);
      cycle(0, '0, 1);
      check("s3_new_addr", ireq.addr, 64'h8000_1000);
      repeat (3) cycle(0, '0, 1);
      check("s3_first_out_pc", out_pc, 64'h8000_1000);
      check("s3_first_out_valid", 64'(out_valid), 64'd1);

      // Two redirects during one discard window: last one wins.
      do_reset();
      lat = 4;
      cycle(0, '0, 1);
      cycle(1, 64'h8000_2000, 1);
      cycle(1, 64'h8000_3000, 1);
      check("s4_addr_held", ireq.addr, 64'h8000_0000);
      repeat (2) cycle(0, '0, 1);
      check("s4_new_addr", ireq.addr, 64'h8000_3000);
      repeat (4) cycle(0, '0, 1);

      // Redirect coinciding with data_ok and a pop while two entries are queued.
      do_reset();
      lat = 1;
      repeat (3) cycle(0, '0, 0);
      check("s5_pre_count", 64'(count), 64'd2);
      cycle(1, 64'h8000_4000, 1);
      check("s5_count_cleared", 64'(count), 64'd0);
      check("s5_out_valid", 64'(out_valid), 64'd0);
      check("s5_redirect_addr", ireq.addr, 64'h8000_4000);
      cycle(0, '0, 1);
      check("s5_out_pc", out_pc, 64'h8000_4000);

      // PC wraps at the top of the address space; unaligned redirect is forced aligned.
      cycle(1, 64'hFFFF_FFFF_FFFF_FFFC, 1);
      check("s6_top_addr", ireq.addr, 64'hFFFF_FFFF_FFFF_FFFC);
      cycle(0, '0, 1);
      check("s6_wrap_addr", ireq.addr, 64'h0);
      cycle(0, '0, 1);
      cycle(1, 64'h8000_0103, 1);
      check("s6_aligned_addr", ireq.addr, 64'h8000_0100);
      repeat (3) cycle(0, '0, 1);

      // Redirect while idle (queue full): fetch restarts on the following cycle.
      do_reset();
      repeat (6) cycle(0, '0, 0);
      cycle(1, 64'h8000_5000, 0);
      check("s7_idle_count", 64'(count), 64'd0);
      check("s7_idle_valid", 64'(ireq.valid), 64'd0);
      check("s7_idle_addr", ireq.addr, 64'h8000_5000);
      cycle(0, '0, 0);
      check("s7_issue_valid", 64'(ireq.valid), 64'd1);
      check("s7_issue_addr", ireq.addr, 64'h8000_5000);

      // Reset in the middle of a slow transaction, then a mixed-ready stream.
      do_reset();
      lat = 3;
      repeat (3) cycle(0, '0, 1);
      do_reset();
      lat = 2;
      for (int i = 0; i < 24; i++) cycle(0, '0, (i % 3) != 0);
      lat = 1;
      for (int i = 0; i < 16; i++) cycle(0, '0, (i % 4) == 1);

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end that decouples instruction-bus latency from the decode stage. It tracks one outstanding ibus transaction at a time, buffers returned instructions with their PCs in a DEPTH-entry FIFO, and takes branch/exception redirects with epoch-style discard of in-flight responses. It sits between the ibus port and the fetch/decode pipeline register of the core, replacing direct PC-hold stalling on `iresp.data_ok`.

## Interface
- DEPTH, 4: FIFO entries. Power of two, ≥2.
- RESET_PC, 64'h8000_0000: fetch PC after reset.
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- ireq  out  ibus_req_t  instruction-bus request (valid, addr)
- iresp  in  ibus_resp_t  instruction-bus response (data_ok, data[31:0])
- redirect_valid  in  1  flush queue and restart fetch at redirect_pc
- redirect_pc  in  64  new fetch PC; bits [1:0] ignored, forced to 0
- out_valid  out  1  head entry valid
- out_pc  out  64  PC of head entry
- out_instr  out  32  instruction of head entry
- out_ready  in  1  consumer accepts head this cycle
- count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Bus rule: once `ireq.valid`=1, `ireq.valid`/`ireq.addr` are held stable until the cycle `iresp.data_ok`=1. At most one transaction outstanding.
- State machine, states IDLE, REQ, DROP:
  - IDLE: `ireq.valid`=0. Go to REQ when count < DEPTH (after this cycle's dequeue) and no redirect, addr = fpc. Redirect: fpc ← redirect_pc, stay IDLE, next cycle evaluates issue.
  - REQ: `ireq.valid`=1, addr = fpc. On data_ok without redirect: enqueue {fpc, data}, fpc ← fpc+4 (64-bit wrap); next REQ if space remains after enqueue/dequeue, else IDLE. Redirect without data_ok: go DROP, tgt ← redirect_pc. Redirect with data_ok same cycle: response discarded, fpc ← redirect_pc, go REQ.
  - DROP: `ireq.valid`=1, addr = old fpc (held). Later redirects overwrite tgt. On data_ok: data discarded, fpc ← tgt (or redirect_pc if redirect same cycle), go REQ.
- Dequeue: `out_valid & out_ready` pops head. Simultaneous enqueue and dequeue leaves count unchanged; permitted when full (no overflow since enqueue is only issued with space reserved).
- Redirect clears FIFO (count ← 0) in the same edge; overrides any same-cycle enqueue or dequeue. Popped-on-redirect head is not considered consumed by the consumer's contract (consumer ignores it).
- Empty: out_valid=0, out_pc/out_instr hold last head contents (don't-care).

## Timing
- Reset: state IDLE, fpc = RESET_PC, count=0, out_valid=0, `ireq.valid`=0, out_pc=0, out_instr=0, pointers 0. First request (`ireq.valid`=1, addr=RESET_PC) in the first cycle after reset deasserts.
- Reset mid-transaction: all state cleared; the pending response is not tracked (bus is reset together).
- Outputs out_* and count are registered-state only; no combinational path from `iresp` or `out_ready` to any output. `ireq` depends only on state/fpc.
- Latency: data_ok at cycle t → out_valid=1 at t+1. Redirect at t with no pending transaction → `ireq.addr`=redirect_pc at t+1. Back-to-back: with data_ok every cycle after issue, one instruction per cycle is enqueued while space exists.

## Structure
- Add to the shared `pipes` package: `fetchq_entry_t` {pc: word_t, instr: u32} and `fetchq_state_t` enum {FQ_IDLE, FQ_REQ, FQ_DROP}.
- One sub-module: `fetchq_fifo` (DEPTH-entry circular buffer, push/pop/clear, count, head); the FSM and PC logic stay in `fetch_queue`.

## Test plan
- Reset then zero-latency bus (data_ok every request cycle), out_ready=1: out_pc sequence 8000_0000, 8000_0004, 8000_0008… one per cycle from cycle 2.
- out_ready=0, DEPTH=4: exactly 4 entries enqueued, count=4, `ireq.valid` drops to 0; assert out_ready for one cycle → one new request issued at addr 8000_0010.
- Bus latency 3 cycles, redirect_valid with redirect_pc=8000_1000 one cycle after issue at 8000_0004: addr held 8000_0004 until data_ok, data discarded, next request addr 8000_1000, first out_pc 8000_1000.
- Two redirects (8000_2000 then 8000_3000) during the same DROP: next request addr 8000_3000.
- Redirect coinciding with data_ok and out_ready with count=2: count=0 next cycle, out_valid=0, response absent from queue, next addr = redirect_pc.
- fpc = FFFF_FFFF_FFFF_FFFC fetch: following addr 0000_0000_0000_0000; redirect_pc=8000_0103 issues addr 8000_0100.
